shiftin: RTL
============

# shiftin

Serial-to-parallel receiver for the three-wire latch/clock/data shift interface our serial output stage drives. It sits directly downstream of that stage, on the same or another board clock domain. It resynchronises SHIFT_LATCH, SHIFT_CLOCK and SHIFT_DATA to CLK, captures one LSB-first frame per latch-low window, and presents the word with a one-cycle valid strobe. Frames of the wrong length are flagged and discarded.

## Interface

- DATA_WIDTH, 32, frame length in bits; also the OUT_DATA width.
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain; must be ≥ 2.

- CLK  input  1  system clock; all logic is on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- SHIFT_LATCH  input  1  frame enable; low during a frame, idle high; asynchronous to CLK.
- SHIFT_CLOCK  input  1  bit clock; data is sampled on its rising edge; asynchronous.
- SHIFT_DATA  input  1  serial data, LSB first; asynchronous.
- OUT_DATA  output  DATA_WIDTH  last good frame; held until the next good frame.
- OUT_VALID  output  1  one-CLK pulse when OUT_DATA is updated.
- FRAME_ERROR  output  1  one-CLK pulse when a frame ends with a bit count other than DATA_WIDTH.
- BUSY  output  1  high while a frame is open (state RECV).

## Operation

- Reset values:
  - OUT_DATA=0, OUT_VALID=0, FRAME_ERROR=0, BUSY=0.
  - State is IDLE; the shift register and bit counter are 0; the overflow flag is clear.
  - The latch synchroniser and its edge-detect register reset to 1; the clock and data synchronisers reset to 0.
- Each input passes through its own SYNC_STAGES-deep chain. Edges are detected by comparing the synchronised value against a one-cycle-delayed copy.
- IDLE:
  - A latch falling edge clears the shift register, the bit counter and the overflow flag, then goes to RECV.
  - Clock edges are ignored.
- RECV, on a clock rising edge:
  - Shift the register right by one and put the synchronised data bit into bit DATA_WIDTH-1. After DATA_WIDTH bits, the first bit received is in bit 0.
  - Increment the bit counter. If the counter is already DATA_WIDTH, set the overflow flag and hold the counter (it saturates).
- RECV, on a latch rising edge: go to IDLE.
  - If counter == DATA_WIDTH and overflow is clear: OUT_DATA <= shift register and pulse OUT_VALID.
  - Otherwise: pulse FRAME_ERROR and leave OUT_DATA unchanged.
- A clock rising edge detected in the same cycle as a latch rising edge is dropped; the latch edge wins.
- A latch falling edge detected while in RECV cannot occur. Both edges of one signal can never be seen in the same cycle.
- Bit counter width is $clog2(DATA_WIDTH+1).
- The default state branch returns to IDLE with no output pulse.
- Reset asserted mid-frame aborts the frame immediately with no OUT_VALID or FRAME_ERROR. After release, a frame starts only on a new latch falling edge.

## Timing

- Synchroniser latency: a pin transition first sampled at CLK edge k is acted on at edge k+SYNC_STAGES+1.
- OUT_VALID and FRAME_ERROR are high for exactly one cycle, starting SYNC_STAGES+1 cycles after the first CLK edge that samples SHIFT_LATCH high. OUT_DATA changes in the same cycle OUT_VALID rises.
- BUSY rises SYNC_STAGES+1 cycles after the latch falling edge is sampled. It falls in the same cycle as the end-of-frame pulse.
- Input requirements:
  - SHIFT_CLOCK high and low phases each ≥ 2 CLK periods.
  - SHIFT_DATA stable from ≥ 1 CLK period before to ≥ 1 CLK period after each SHIFT_CLOCK rise.
  - SHIFT_LATCH stays low ≥ 2 CLK periods after the last SHIFT_CLOCK rise.
- With these constraints met, a source running at 4 or more CLK periods per bit on the same CLK frequency is received without loss.
- There is no backpressure. Back-to-back frames are accepted once SHIFT_LATCH has been high for ≥ 2 CLK periods.

## Test plan

- **Good frame.** DATA_WIDTH=32, 8 CLK per bit; drive 0xA5C3_0F81 LSB first, then raise the latch → OUT_DATA=0xA5C30F81, one OUT_VALID pulse, FRAME_ERROR stays 0, BUSY high only during the frame.
- **Short and long frames.** Send 31 bits, then 33 bits (the extra bit is 1) → FRAME_ERROR pulses once per frame, OUT_VALID stays 0, OUT_DATA keeps its previous value.
- **Back-to-back frames.** Send 0x0000_0001 then 0xFFFF_FFFF with the latch high for 2 CLK between them → two OUT_VALID pulses with those exact values, in order.
- **Reset mid-frame.** Pulse RST_N low after 16 bits → all outputs 0 immediately. A following full frame of 0x1234_5678 yields OUT_VALID with OUT_DATA=0x12345678.
- **Same-cycle edges and stray clocks.** Raise SHIFT_CLOCK and SHIFT_LATCH on the same CLK edge after 32 bits → the 33rd edge is dropped and OUT_VALID fires. Toggle SHIFT_CLOCK while the latch is high → no output change.
- **Minimum-rate source.** Drive the frame from the matching serial output stage at 4 CLK per bit with random data, 100 frames → every OUT_DATA matches the transmitted word.

Source files
------------

// File: rtl/shiftin.sv
// rtl/shiftin.sv - serial latch/clock/data receiver with framed parallel output
module shiftin #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SHIFT_LATCH,
  input  logic                  SHIFT_CLOCK,
  input  logic                  SHIFT_DATA,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  output logic                  FRAME_ERROR,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clock_sync;
  logic [SYNC_STAGES-1:0] data_sync;

  logic latch_s;
  logic clock_s;
  logic data_s;

  logic latch_d;
  logic clock_d;
  logic latch_rise_r;
  logic latch_fall_r;
  logic clock_rise_r;
  logic data_r;

  state_t                  state;
  state_t                  state_n;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shift_reg_n;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        bit_cnt_n;
  logic                    overflow;
  logic                    overflow_n;
  logic [DATA_WIDTH-1:0]   out_data_n;
  logic                    out_valid_n;
  logic                    frame_error_n;

  assign latch_s = latch_sync[SYNC_STAGES-1];
  assign clock_s = clock_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];

  // Resynchronise the three asynchronous pins; latch idles high so its chain resets to 1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      latch_sync <= '1;
      clock_sync <= '0;
      data_sync  <= '0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], SHIFT_LATCH};
      clock_sync <= {clock_sync[SYNC_STAGES-2:0], SHIFT_CLOCK};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], SHIFT_DATA};
    end
  end

  // Edge detection against a delayed copy; edges and the data bit are registered together so they stay aligned
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      latch_d      <= 1'b1;
      clock_d      <= 1'b0;
      latch_rise_r <= 1'b0;
      latch_fall_r <= 1'b0;
      clock_rise_r <= 1'b0;
      data_r       <= 1'b0;
    end else begin
      latch_d      <= latch_s;
      clock_d      <= clock_s;
      latch_rise_r <= latch_s & ~latch_d;
      latch_fall_r <= ~latch_s & latch_d;
      clock_rise_r <= clock_s & ~clock_d;
      data_r       <= data_s;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath decisions; a latch rise in the same cycle as a clock rise takes priority
  always_comb begin
    state_n       = state;
    shift_reg_n   = shift_reg;
    bit_cnt_n     = bit_cnt;
    overflow_n    = overflow;
    out_data_n    = OUT_DATA;
    out_valid_n   = 1'b0;
    frame_error_n = 1'b0;
    case (state)
      IDLE: begin
        if (latch_fall_r) begin
          shift_reg_n = '0;
          bit_cnt_n   = '0;
          overflow_n  = 1'b0;
          state_n     = RECV;
        end
      end
      RECV: begin
        if (latch_rise_r) begin
          state_n = IDLE;
          if (bit_cnt == CNT_FULL && !overflow) begin
            out_data_n  = shift_reg;
            out_valid_n = 1'b1;
          end else begin
            frame_error_n = 1'b1;
          end
        end else if (clock_rise_r) begin
          shift_reg_n = {data_r, shift_reg[DATA_WIDTH-1:1]};
          if (bit_cnt == CNT_FULL) begin
            overflow_n = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      overflow    <= 1'b0;
      OUT_DATA    <= '0;
      OUT_VALID   <= 1'b0;
      FRAME_ERROR <= 1'b0;
    end else begin
      shift_reg   <= shift_reg_n;
      bit_cnt     <= bit_cnt_n;
      overflow    <= overflow_n;
      OUT_DATA    <= out_data_n;
      OUT_VALID   <= out_valid_n;
      FRAME_ERROR <= frame_error_n;
    end
  end

  assign BUSY = (state == RECV);

endmodule
